fmesh_adaptive_route_unit: RTL
==============================

Name: fmesh_adaptive_route_unit

Overview:
- Registered, congestion-aware destination-port generator for one input port of an fmesh router.
- Decodes the look-ahead coded destination {x,y,a,b} of a head flit into a one-hot output-port vector.
- For fully adaptive routing, it keeps a per-quadrant X-vs-Y port preselection that is updated from neighbour credit counts with hysteresis.
- Sits between the input-port head-flit buffer and the VC/switch allocator. One-stage valid/ready pipeline.

Parameters:
- ROUTE_TYPE, "DETERMINISTIC", "DETERMINISTIC" forces every preselection bit to 1; "FULL_ADAPTIVE" uses the learned preselection.
- NL, 1, local ports per router.
- P, 5+NL-1, router port count.
- SW_LOC, 0, index of the port this unit serves; it is removed from the output unless SELF_LOOP_EN.
- SELF_LOOP_EN, 0, keep the SW_LOC bit in the output.
- PLw, log2(P), width of endp_localp_num.
- CRw, 4, width of one neighbour credit count.
- SAMPLE_PERIOD, 16, cycles between preselection updates (≥1).
- THR, 2, credit difference that counts as a congestion vote.
- HW, 3, hysteresis counter width.
- PRESEL_INIT, 4'b1111, preselection value at reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  head flit present
- in_ready  out  1  unit can accept
- dest_port_coded  in  4  {x,y,a,b}
- endp_localp_num  in  PLw  local port index, used when a=b=0
- swap_port_presel  in  1  invert the preselection for this flit (odd column)
- credit_cnt  in  4*CRw  free credits per neighbour; slice p-1 belongs to port p (1=E, 2=N, 3=W, 4=S)
- out_valid  out  1  registered result valid
- out_ready  in  1  allocator accepts
- dest_port  out  P_1  one-hot destination; P_1 = SELF_LOOP_EN ? P : P-1
- port_pre_sel  out  4  current preselection, for debug and the allocator

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. While reset is high:
  - out_valid=0, dest_port=0.
  - port_pre_sel=PRESEL_INIT.
  - Every hysteresis counter = 2^(HW-1).
  - Sample counter = 0.
  - in_ready is 1 in the cycle after reset deasserts.
- Handshake:
  - in_ready = ~out_valid | out_ready.
  - Transfer in: in_valid & in_ready. The result is registered with latency exactly 1 cycle.
  - out_valid and dest_port are held stable until out_ready.
  - Back-to-back transfers at full throughput.
  - Transfer in with out_ready=1 in the same cycle replaces the result; it is neither dropped nor duplicated.
- Decode (quadrant q={x,y}):
  - ab=10: E if x=1, W if x=0.
  - ab=01: N if y=1, S if y=0.
  - ab=00: one-hot(endp_localp_num).
  - ab=11: Y port if sel[q]=1, else X port.
  - sel = all-ones when DETERMINISTIC; otherwise sel = swap ? ~port_pre_sel : port_pre_sel.
  - Bits NL..P-1 are zero-extended for non-local results.
  - When SELF_LOOP_EN=0, bit SW_LOC is removed by index compaction.
  - An endp_localp_num ≥ P gives dest_port=0; the out_valid handshake still completes.
- Preselection update (FULL_ADAPTIVE only; otherwise the counters stay frozen):
  - The sample counter counts 0..SAMPLE_PERIOD-1 and wraps; the tick is at SAMPLE_PERIOD-1.
  - On a tick, for each q, with cy = credits of the Y port and cx = credits of the X port:
    - If cy ≥ cx+THR, increment the counter.
    - Else if cx ≥ cy+THR, decrement it.
    - Else hold.
    - Compare at CRw+1 bits, with no overflow.
  - Counter reaches 2^HW-1: set port_pre_sel[q]=1 and reload 2^(HW-1).
  - Counter reaches 0: clear port_pre_sel[q] and reload 2^(HW-1).
  - The update lands in the cycle after the tick. A flit accepted in the tick cycle uses the old value.
- Reset asserted mid-transfer: the pending result is discarded and nothing is emitted.

Decomposition:
- Shared package: the fmesh port-index constants (LOCAL=0, E=1, N=2, W=3, S=4), the coded-destination struct {x,y,a,b}, and the P_1 function.
- Sub-module fmesh_presel_tracker holds the sample counter, the four hysteresis counters and port_pre_sel.
- Decode and the output register stay in the top module, reusing remove_sw_loc_one_hot.

Test Plan:
- DETERMINISTIC, SW_LOC=0, code 4'b1010, out_ready=1 -> next cycle out_valid=1, dest_port=4'b0001 (E).
- DETERMINISTIC, code 4'b0111 -> Y selected, y=1 -> dest_port=4'b0010 (N); code 4'b0011 -> 4'b1000 (S).
- out_ready=0 for 3 cycles after the first result -> in_ready=0, dest_port held; on release both a queued second flit and the first transfer correctly.
- FULL_ADAPTIVE, SAMPLE_PERIOD=4, HW=3, N credits=1, E credits=8, q=2'b11 -> port_pre_sel[3] falls to 0 after 4 ticks (cycle 16) -> code 4'b1111 gives E (4'b0001); with swap=1 it gives N.
- Credit difference of 1 < THR for 100 cycles -> port_pre_sel stays 4'b1111.
- Reset asserted while out_valid=1 -> out_valid=0, port_pre_sel=PRESEL_INIT next cycle, and no stray output after reset deasserts.

Source files
------------

// File: rtl/fmesh_adaptive_route_unit_pkg.sv
// ---------------------------------------------------------------------------
// fmesh_adaptive_route_unit_pkg
//   Shared definitions for the fmesh adaptive route unit:
//   - fmesh port-index constants (LOCAL, E, N, W, S)
//   - the look-ahead coded destination struct {x,y,a,b}
//   - route-kind and congestion-vote enums
//   - p_1(): width of the destination vector once the own port is removed
//   - remove_sw_loc_one_hot(): compacts a one-hot vector by dropping one bit
// ---------------------------------------------------------------------------
package fmesh_adaptive_route_unit_pkg;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_E     = 1;
  localparam int PORT_N     = 2;
  localparam int PORT_W     = 3;
  localparam int PORT_S     = 4;

  typedef struct packed {
    logic x;
    logic y;
    logic a;
    logic b;
  } dest_coded_t;

  // {a,b} selects what kind of hop the head flit asks for
  typedef enum logic [1:0] {
    ROUTE_LOCAL = 2'b00,
    ROUTE_Y     = 2'b01,
    ROUTE_X     = 2'b10,
    ROUTE_ADAPT = 2'b11
  } route_kind_e;

  typedef enum logic [1:0] {
    VOTE_HOLD = 2'b00,
    VOTE_UP   = 2'b01,
    VOTE_DOWN = 2'b10
  } vote_e;

  function automatic int p_1(input int p, input bit self_loop_en);
    return self_loop_en ? p : p - 1;
  endfunction

  // Bits below sw_loc stay in place, bits above it shift down by one,
  // and bit sw_loc itself disappears.
  function automatic logic [31:0] remove_sw_loc_one_hot(input logic [31:0] onehot,
                                                         input int sw_loc);
    logic [31:0] lowMask;
    lowMask = (32'd1 << sw_loc) - 32'd1;
    return (onehot & lowMask) | ((onehot >> 1) & ~lowMask);
  endfunction

endpackage

// File: rtl/fmesh_adaptive_route_unit_presel_tracker.sv
// ---------------------------------------------------------------------------
// fmesh_presel_tracker
//   Learns, per quadrant q={x,y}, whether the Y or the X output port should
//   be preferred for fully adaptive head flits. Every SAMPLE_PERIOD cycles the
//   neighbour credit counts cast a vote into a small hysteresis counter; the
//   preselection bit only flips when that counter saturates.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   credit_cnt     free credits per neighbour, slice p-1 belongs to port p
//   port_pre_sel   current preselection (1 = prefer Y port) per quadrant
// ---------------------------------------------------------------------------
module fmesh_presel_tracker
  import fmesh_adaptive_route_unit_pkg::*;
#(
  parameter bit         ADAPTIVE      = 1'b0,
  parameter int         CRw           = 4,
  parameter int         SAMPLE_PERIOD = 16,
  parameter int         THR           = 2,
  parameter int         HW            = 3,
  parameter logic [3:0] PRESEL_INIT   = 4'b1111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4*CRw-1:0] credit_cnt,
  output logic [3:0]       port_pre_sel
);

  localparam int               SCW         = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [SCW-1:0]   LAST_SAMPLE = SCW'(SAMPLE_PERIOD - 1);
  localparam logic [HW-1:0]    HMID        = HW'(1) << (HW - 1);
  localparam logic [HW-1:0]    HMAX        = '1;
  localparam logic [CRw:0]     THR_W       = (CRw + 1)'(THR);

  logic [SCW-1:0]       sample_q, sample_d;
  logic [3:0][HW-1:0]   hyst_q, hyst_d;
  logic [3:0]           presel_q, presel_d;
  logic                 tick;
  logic [CRw:0]         cy, cx;
  logic [HW-1:0]        cnt;
  vote_e                vote;

  function automatic logic [CRw-1:0] port_credit(input logic [4*CRw-1:0] cr, input int port);
    return cr[(port - 1) * CRw +: CRw];
  endfunction

  // Sample counter and per-quadrant voting. Credits are widened by one bit so
  // that "cx + THR" cannot wrap around and fake a vote. In DETERMINISTIC mode
  // everything is frozen at its reset value.
  always_comb begin
    tick     = (sample_q == LAST_SAMPLE);
    sample_d = sample_q;
    hyst_d   = hyst_q;
    presel_d = presel_q;
    cy       = '0;
    cx       = '0;
    cnt      = '0;
    vote     = VOTE_HOLD;
    if (ADAPTIVE) begin
      sample_d = tick ? '0 : sample_q + 1'b1;
      if (tick) begin
        for (int q = 0; q < 4; q++) begin
          cy = {1'b0, port_credit(credit_cnt, (q % 2 == 1) ? PORT_N : PORT_S)};
          cx = {1'b0, port_credit(credit_cnt, (q / 2 == 1) ? PORT_E : PORT_W)};
          if (cy >= cx + THR_W) begin
            vote = VOTE_UP;
          end else if (cx >= cy + THR_W) begin
            vote = VOTE_DOWN;
          end else begin
            vote = VOTE_HOLD;
          end
          cnt = hyst_q[q];
          case (vote)
            VOTE_UP:   cnt = cnt + 1'b1;
            VOTE_DOWN: cnt = cnt - 1'b1;
            default:   cnt = hyst_q[q];
          endcase
          // Saturation flips the preference and recentres the counter
          if (vote != VOTE_HOLD && cnt == HMAX) begin
            presel_d[q] = 1'b1;
            cnt         = HMID;
          end else if (vote != VOTE_HOLD && cnt == '0) begin
            presel_d[q] = 1'b0;
            cnt         = HMID;
          end
          hyst_d[q] = cnt;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '0;
      hyst_q   <= {4{HMID}};
      presel_q <= PRESEL_INIT;
    end else begin
      sample_q <= sample_d;
      hyst_q   <= hyst_d;
      presel_q <= presel_d;
    end
  end

  assign port_pre_sel = presel_q;

endmodule

// File: rtl/fmesh_adaptive_route_unit.sv
// ---------------------------------------------------------------------------
// fmesh_adaptive_route_unit
//   Registered, congestion-aware destination-port generator for one input
//   port of an fmesh router. Decodes the look-ahead coded destination of a
//   head flit into a one-hot output-port vector behind a one-stage
//   valid/ready register.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   in_valid/in_ready  head-flit handshake from the input buffer
//   dest_port_coded    {x,y,a,b} look-ahead destination
//   endp_localp_num    local port index used when a=b=0
//   swap_port_presel   invert the preselection for this flit (odd column)
//   credit_cnt         neighbour free credits (E,N,W,S slices)
//   out_valid/ready    result handshake towards the VC/switch allocator
//   dest_port          one-hot destination, own port removed unless self-loop
//   port_pre_sel       current per-quadrant Y-vs-X preselection
// ---------------------------------------------------------------------------
module fmesh_adaptive_route_unit
  import fmesh_adaptive_route_unit_pkg::*;
#(
  parameter string      ROUTE_TYPE    = "DETERMINISTIC",
  parameter int         NL            = 1,
  parameter int         P             = 5 + NL - 1,
  parameter int         SW_LOC        = 0,
  parameter int         SELF_LOOP_EN  = 0,
  parameter int         PLw           = $clog2(P),
  parameter int         CRw           = 4,
  parameter int         SAMPLE_PERIOD = 16,
  parameter int         THR           = 2,
  parameter int         HW            = 3,
  parameter logic [3:0] PRESEL_INIT   = 4'b1111,
  localparam int        P_1           = p_1(P, SELF_LOOP_EN != 0)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       dest_port_coded,
  input  logic [PLw-1:0]   endp_localp_num,
  input  logic             swap_port_presel,
  input  logic [4*CRw-1:0] credit_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_1-1:0]   dest_port,
  output logic [3:0]       port_pre_sel
);

  localparam bit IS_ADAPTIVE = (ROUTE_TYPE == "FULL_ADAPTIVE");

  dest_coded_t    coded;
  logic [1:0]     quad;
  logic [3:0]     sel;
  logic [P-1:0]   route_full;
  logic [P_1-1:0] route_compact;
  logic           xfer_in;
  logic           out_valid_q, out_valid_d;
  logic [P_1-1:0] dest_q, dest_d;

  fmesh_presel_tracker #(
    .ADAPTIVE      (IS_ADAPTIVE),
    .CRw           (CRw),
    .SAMPLE_PERIOD (SAMPLE_PERIOD),
    .THR           (THR),
    .HW            (HW),
    .PRESEL_INIT   (PRESEL_INIT)
  ) u_presel_tracker (
    .clk          (clk),
    .reset        (reset),
    .credit_cnt   (credit_cnt),
    .port_pre_sel (port_pre_sel)
  );

  assign coded = dest_coded_t'(dest_port_coded);
  assign quad  = {coded.x, coded.y};

  // Destination decode. For adaptive hops the quadrant's preselection picks
  // the Y port (1) or the X port (0); odd columns see it inverted. Local
  // indices beyond the port count decode to an empty vector.
  always_comb begin
    sel        = IS_ADAPTIVE ? (swap_port_presel ? ~port_pre_sel : port_pre_sel) : 4'b1111;
    route_full = '0;
    case (route_kind_e'({coded.a, coded.b}))
      ROUTE_X: route_full[coded.x ? PORT_E : PORT_W] = 1'b1;
      ROUTE_Y: route_full[coded.y ? PORT_N : PORT_S] = 1'b1;
      ROUTE_LOCAL: begin
        for (int i = 0; i < P; i++) begin
          if (endp_localp_num == PLw'(i)) route_full[i] = 1'b1;
        end
      end
      default: begin
        if (sel[quad]) route_full[coded.y ? PORT_N : PORT_S] = 1'b1;
        else           route_full[coded.x ? PORT_E : PORT_W] = 1'b1;
      end
    endcase
  end

  // Drop the bit of the port this unit serves unless self-loops are allowed
  assign route_compact = (SELF_LOOP_EN != 0) ? P_1'(route_full)
                       : P_1'(remove_sw_loc_one_hot(32'(route_full), SW_LOC));

  assign in_ready = ~out_valid_q | out_ready;
  assign xfer_in  = in_valid & in_ready;

  // Output stage: load on an accepted flit (even while the old result is
  // leaving), otherwise hold until the allocator takes it.
  always_comb begin
    out_valid_d = out_valid_q;
    dest_d      = dest_q;
    if (xfer_in) begin
      out_valid_d = 1'b1;
      dest_d      = route_compact;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dest_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dest_q      <= dest_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dest_port = dest_q;

endmodule
